// File: rtl/s4ga_cfg_sequencer_if.sv
// Byte-wide configuration bus into the S4GA configuration sequencer.
//
// Handshake: a byte moves on a rising clock edge where cfg_valid and
// cfg_ready are both high. The master holds cfg_data stable while
// cfg_valid is high and the byte has not yet moved. cfg_ready does not
// depend on cfg_valid. Nothing moves while either signal is low.
interface s4ga_cfg_sequencer_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/s4ga_cfg_sequencer.sv
// S4GA configuration sequencer: takes bitstream bytes, shifts them into the
// fabric as nibbles (high nibble first), checks the trailing XOR checksum and
// releases the fabric reset only after a clean load.
module s4ga_cfg_sequencer #(
  parameter int CFG_NIBBLES = 2048,
  parameter int CNT_W       = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  s4ga_cfg_sequencer_if.slave   cfg,
  output logic [3:0]            si,
  output logic                  si_en,
  output logic                  fabric_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SHIFT_HI  = 3'd2,
    SHIFT_LO  = 3'd3,
    WAIT_SUM  = 3'd4,
    RUN       = 3'd5,
    ERR       = 3'd6
  } state_t;

  // Byte count at which the data phase ends. If CFG_NIBBLES/2 equals
  // 2**CNT_W the truncation yields 0, which is where the counter wraps to.
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CFG_NIBBLES / 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       si_q, si_d;
  logic             ready_q, ready_d;
  logic             si_en_q, si_en_d;
  logic             frst_n_q, frst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;

  assign accept = cfg.cfg_valid && ready_q;

  // Next state, datapath updates, and next values of the registered outputs.
  // Outputs are decoded from the next state so they line up with the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    byte_d  = byte_q;
    si_d    = si_q;
    if (cfg_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, RUN, ERR: begin
          if (cfg_start) begin
            state_d = WAIT_BYTE;
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
        WAIT_BYTE: begin
          if (accept) begin
            byte_d  = cfg.cfg_data;
            sum_d   = sum_q ^ cfg.cfg_data;
            cnt_d   = cnt_q + CNT_W'(1);
            si_d    = cfg.cfg_data[7:4];
            state_d = SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          si_d    = byte_q[3:0];
          state_d = SHIFT_LO;
        end
        SHIFT_LO: begin
          state_d = (cnt_q == LAST_BYTE) ? WAIT_SUM : WAIT_BYTE;
        end
        WAIT_SUM: begin
          // The checksum byte is compared only, never shifted out.
          if (accept) begin
            state_d = (cfg.cfg_data == sum_q) ? RUN : ERR;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ready_d  = (state_d == WAIT_BYTE) || (state_d == WAIT_SUM);
    si_en_d  = (state_d == SHIFT_HI) || (state_d == SHIFT_LO);
    busy_d   = (state_d == WAIT_BYTE) || (state_d == SHIFT_HI) ||
               (state_d == SHIFT_LO) || (state_d == WAIT_SUM);
    done_d   = (state_d == RUN);
    err_d    = (state_d == ERR);
    frst_n_d = (state_d == RUN);
  end

  // State, datapath and output registers; async reset parks everything idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      byte_q   <= '0;
      si_q     <= '0;
      ready_q  <= 1'b0;
      si_en_q  <= 1'b0;
      frst_n_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      byte_q   <= byte_d;
      si_q     <= si_d;
      ready_q  <= ready_d;
      si_en_q  <= si_en_d;
      frst_n_q <= frst_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign si            = si_q;
  assign si_en         = si_en_q;
  assign fabric_rst_n  = frst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule
